hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of each saturating performance counter.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 FW_halt  in  1  load-use halt request from the forwarding unit, same cycle as the EX operands.
REQ-005 icache_stall  in  1  instruction cache miss pending.
REQ-006 dcache_stall  in  1  data cache miss pending.
REQ-007 br_mispredict  in  1  branch/jump in EX resolved against the prediction.
REQ-008 stall_if, stall_id, stall_ex, stall_mem, stall_wb  out  1 each  hold the corresponding pipeline register.
REQ-009 flush_id, flush_ex  out  1 each  replace the IF/ID and ID/EX register contents with a NOP.
REQ-010 kill_mem  out  1  insert a bubble (reg_wen=0, cpu_write=0) into EX/MEM.
REQ-011 redirect  out  1  select the corrected PC in IF.
REQ-012 fw_cnt, cache_cnt, flush_cnt  out  CNT_W each  stall/flush event counters.
REQ-013 proto_err  out  1  sticky: FW_halt held for 2 consecutive cycles.

Function
REQ-014 The FSM SHALL have states RUN, FW_STALL, CACHE_STALL.
REQ-015 Control outputs (REQ-008..011) SHALL be combinational from the current state, the inputs and flush_pend, with zero-cycle latency relative to the inputs.
REQ-016 Priority SHALL be: cache stall > FW_halt > br_mispredict > flush_pend.
REQ-017 Cache stall (icache_stall|dcache_stall) in any state: all stall_* =1; flush_*, kill_mem and redirect =0; next state CACHE_STALL.
REQ-018 CACHE_STALL -> RUN on the first cycle both cache stalls are 0; that cycle follows RUN rules.
REQ-019 br_mispredict while a cache stall is active SHALL set flush_pend; flush_pend clears when the flush is issued.
REQ-020 FW_halt in RUN/FW_STALL without a cache stall: stall_if/id/ex=1, kill_mem=1, stall_mem/wb=0; next state FW_STALL.
REQ-021 FW_STALL lasts exactly one cycle, then returns to RUN.
REQ-022 FW_halt in a FW_STALL cycle SHALL set proto_err and still stall (REQ-020).
REQ-023 br_mispredict coincident with FW_halt SHALL be ignored; the branch re-resolves after the stall.
REQ-024 Flush (br_mispredict or flush_pend, no higher cause): flush_id=flush_ex=redirect=1 for one cycle; all stall_* =0.
REQ-025 No cause active: all control outputs =0.
REQ-026 fw_cnt +1 per FW_halt stall cycle; cache_cnt +1 per cache-stall cycle; flush_cnt +1 per issued flush; each SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-027 rst_n=0 SHALL immediately force state=RUN, flush_pend=0, proto_err=0, all counters=0, independent of clk.
REQ-028 Reset during CACHE_STALL or FW_STALL SHALL abandon the stall; a pending flush is lost.
REQ-029 Following reset release, the first edge SHALL evaluate the inputs in RUN.

Structure
REQ-030 The state enum hz_state_e (RUN, FW_STALL, CACHE_STALL) and the CNT_W default SHALL be placed in RVS192_package.
REQ-031 A sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) SHALL implement each counter, instantiated three times.

Verification
REQ-032 Verification SHALL cover the following directed scenarios:
- FW_halt=1 for 1 cycle in RUN -> that cycle stall_if/id/ex=1 and kill_mem=1; next cycle all outputs 0; fw_cnt=1, proto_err=0.
- FW_halt=1 for 2 cycles -> proto_err=1 from the 3rd edge on; fw_cnt=2.
- dcache_stall=1 for 5 cycles with br_mispredict=1 in cycle 2 -> all stall_*=1 for 5 cycles; then a 1-cycle flush_id/flush_ex/redirect; cache_cnt=5, flush_cnt=1.
- FW_halt and br_mispredict together -> stall with no flush; next cycle br_mispredict alone -> flush; flush_cnt=1.
- CNT_W=4, cache stall held 20 cycles -> cache_cnt sticks at 15.
- rst_n=0 mid CACHE_STALL with flush_pend=1 -> counters=0 asynchronously; no redirect after release.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
`timescale 1ns/1ps
package RVS192_package;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      FW_STALL    = 2'd1,
      CACHE_STALL = 2'd2
   } hz_state_e;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-controller bundle: stall/flush causes in, pipeline control and event counters out.
`timescale 1ns/1ps
interface hazard_stall_ctrl_if #(parameter int CNT_W = RVS192_package::CNT_W_DEF);
   logic             FW_halt;
   logic             icache_stall;
   logic             dcache_stall;
   logic             br_mispredict;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             stall_mem;
   logic             stall_wb;
   logic             flush_id;
   logic             flush_ex;
   logic             kill_mem;
   logic             redirect;
   logic [CNT_W-1:0] fw_cnt;
   logic [CNT_W-1:0] cache_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             proto_err;

   modport master (
      output FW_halt, icache_stall, dcache_stall, br_mispredict,
      input  stall_if, stall_id, stall_ex, stall_mem, stall_wb,
      input  flush_id, flush_ex, kill_mem, redirect,
      input  fw_cnt, cache_cnt, flush_cnt, proto_err
   );

   modport slave (
      input  FW_halt, icache_stall, dcache_stall, br_mispredict,
      output stall_if, stall_id, stall_ex, stall_mem, stall_wb,
      output flush_id, flush_ex, kill_mem, redirect,
      output fw_cnt, cache_cnt, flush_cnt, proto_err
   );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, holds at all-ones, async clear.
`timescale 1ns/1ps
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush arbiter: control outputs are combinational (zero latency) from inputs and state.
// Priority cache stall > load-use halt > mispredict > deferred flush; counters saturate.
`timescale 1ns/1ps
module hazard_stall_ctrl
   import RVS192_package::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_stall_ctrl_if.slave  hz
);
   hz_state_e        r_state;
   hz_state_e        w_state_nxt;
   logic             r_flush_pend;
   logic             w_flush_pend_nxt;
   logic             r_proto_err;
   logic             w_cache;
   logic             w_fw_stall;
   logic             w_flush;
   logic             w_stall_front;
   logic             w_stall_back;
   logic             w_kill_mem;
   logic [CNT_W-1:0] w_fw_cnt;
   logic [CNT_W-1:0] w_cache_cnt;
   logic [CNT_W-1:0] w_flush_cnt;

   assign w_cache = hz.icache_stall | hz.dcache_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_flush_pend <= w_flush_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = RUN;
      w_flush_pend_nxt = r_flush_pend;
      w_stall_front    = 1'b0;
      w_stall_back     = 1'b0;
      w_kill_mem       = 1'b0;
      w_fw_stall       = 1'b0;
      w_flush          = 1'b0;
      if (w_cache) begin
         w_stall_front = 1'b1;
         w_stall_back  = 1'b1;
         w_state_nxt   = CACHE_STALL;
         // A mispredict seen under a cache miss is replayed once the miss clears.
         if (hz.br_mispredict) begin
            w_flush_pend_nxt = 1'b1;
         end
      end else if (hz.FW_halt) begin
         // Mispredict is dropped here; the branch is still in EX after the bubble.
         w_stall_front = 1'b1;
         w_kill_mem    = 1'b1;
         w_fw_stall    = 1'b1;
         w_state_nxt   = FW_STALL;
      end else if (hz.br_mispredict || r_flush_pend) begin
         w_flush          = 1'b1;
         w_flush_pend_nxt = 1'b0;
      end
   end

   // A second halt request right after a load-use bubble means the forwarding unit misbehaved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_proto_err <= 1'b0;
      end else if ((r_state == FW_STALL) && hz.FW_halt) begin
         r_proto_err <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_fw_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_fw_stall),
      .cnt   (w_fw_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cache_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_cache),
      .cnt   (w_cache_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_flush),
      .cnt   (w_flush_cnt)
   );

   assign hz.stall_if  = w_stall_front;
   assign hz.stall_id  = w_stall_front;
   assign hz.stall_ex  = w_stall_front;
   assign hz.stall_mem = w_stall_back;
   assign hz.stall_wb  = w_stall_back;
   assign hz.flush_id  = w_flush;
   assign hz.flush_ex  = w_flush;
   assign hz.redirect  = w_flush;
   assign hz.kill_mem  = w_kill_mem;
   assign hz.fw_cnt    = w_fw_cnt;
   assign hz.cache_cnt = w_cache_cnt;
   assign hz.flush_cnt = w_flush_cnt;
   assign hz.proto_err = r_proto_err;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: inputs driven on the falling edge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   // {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex, kill_mem, redirect}
   localparam logic [8:0] C_IDLE  = 9'b000000000;
   localparam logic [8:0] C_FW    = 9'b111000010;
   localparam logic [8:0] C_CACHE = 9'b111110000;
   localparam logic [8:0] C_FLUSH = 9'b000001101;

   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(16)) hz ();
   hazard_stall_ctrl_if #(.CNT_W(4))  hz4 ();

   hazard_stall_ctrl #(.CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   hazard_stall_ctrl #(.CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz4.slave)
   );

   function automatic logic [8:0] ctl();
      return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem, hz.stall_wb,
              hz.flush_id, hz.flush_ex, hz.kill_mem, hz.redirect};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic fw, input logic ic, input logic dc, input logic br);
      @(negedge clk);
      hz.FW_halt       = fw;
      hz.icache_stall  = ic;
      hz.dcache_stall  = dc;
      hz.br_mispredict = br;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      hz.FW_halt = 1'b0; hz.icache_stall = 1'b0; hz.dcache_stall = 1'b0; hz.br_mispredict = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_proto_err", 32'(hz.proto_err), 32'h0);
      chk("rst_counters", {8'h0, 8'(hz.fw_cnt), 8'(hz.cache_cnt), 8'(hz.flush_cnt)}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      hz.FW_halt = 1'b0; hz.icache_stall = 1'b0; hz.dcache_stall = 1'b0; hz.br_mispredict = 1'b0;
      hz4.FW_halt = 1'b0; hz4.icache_stall = 1'b0; hz4.dcache_stall = 1'b0; hz4.br_mispredict = 1'b0;
      #12;
      chk("init_ctl", 32'(ctl()), 32'(C_IDLE));
      chk("init_fw_cnt", 32'(hz.fw_cnt), 32'h0);
      chk("init_proto_err", 32'(hz.proto_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single load-use halt
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fw1_ctl", 32'(ctl()), 32'(C_FW));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fw1_after_ctl", 32'(ctl()), 32'(C_IDLE));
      chk("fw1_cnt", 32'(hz.fw_cnt), 32'd1);
      chk("fw1_proto_err", 32'(hz.proto_err), 32'h0);

      // back-to-back halt: still stalls, flags protocol error
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fw2_ctl_a", 32'(ctl()), 32'(C_FW));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fw2_ctl_b", 32'(ctl()), 32'(C_FW));
      chk("fw2_proto_before", 32'(hz.proto_err), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fw2_proto_after", 32'(hz.proto_err), 32'h1);
      chk("fw2_cnt", 32'(hz.fw_cnt), 32'd3);
      chk("fw2_idle", 32'(ctl()), 32'(C_IDLE));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fw2_proto_sticky", 32'(hz.proto_err), 32'h1);

      // dcache miss for 5 cycles with mispredict in cycle 2
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("dc_c1", 32'(ctl()), 32'(C_CACHE));
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("dc_c2_br", 32'(ctl()), 32'(C_CACHE));
      for (int i = 3; i <= 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("dc_cN", 32'(ctl()), 32'(C_CACHE));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("dc_pend_flush", 32'(ctl()), 32'(C_FLUSH));
      chk("dc_cache_cnt", 32'(hz.cache_cnt), 32'd5);
      chk("dc_flush_cnt_pre", 32'(hz.flush_cnt), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("dc_after_flush", 32'(ctl()), 32'(C_IDLE));
      chk("dc_flush_cnt", 32'(hz.flush_cnt), 32'd1);

      // halt with coincident mispredict: mispredict ignored, re-resolved next cycle
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("fwbr_ctl", 32'(ctl()), 32'(C_FW));
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("fwbr_flush", 32'(ctl()), 32'(C_FLUSH));
      chk("fwbr_fw_cnt", 32'(hz.fw_cnt), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fwbr_idle", 32'(ctl()), 32'(C_IDLE));
      chk("fwbr_flush_cnt", 32'(hz.flush_cnt), 32'd1);

      // saturation on the 4-bit instance
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         hz4.icache_stall = 1'b1;
      end
      @(negedge clk);
      hz4.icache_stall = 1'b0;
      #1;
      chk("sat_cache_cnt4", 32'(hz4.cache_cnt), 32'd15);

      // reset in the middle of a cache stall with a pending flush
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      chk("mid_cache_cnt_pre", 32'(hz.cache_cnt), 32'd2);
      hz.dcache_stall = 1'b0; hz.br_mispredict = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cache_cnt", 32'(hz.cache_cnt), 32'd0);
      chk("mid_rst_ctl", 32'(ctl()), 32'(C_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_no_redirect", 32'(ctl()), 32'(C_IDLE));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_flush_cnt", 32'(hz.flush_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
